alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered, multi-cycle successor to the combinational datapath ALU.
- Executes ADD/SUB/AND/OR/SLT in one clock. MUL (shift-add) and DIV (restoring) are iterative and take WIDTH clocks.
- Uses a start/busy/done handshake with the control unit.
- Adds an error flag for divide-by-zero and illegal opcodes, and holds its result stably between operations.

Parameters:
- WIDTH, 32, operand/result width in bits (legal range 4..64).
- CW, 6, iteration counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- OP1  input  WIDTH  first operand (unsigned), captured when start is accepted.
- OP2  input  WIDTH  second operand (unsigned), captured when start is accepted.
- ALUSel  input  4  operation code, captured when start is accepted.
- Res  output  WIDTH  registered result; holds until the next completed operation.
- Z  output  1  registered; 1 when Res==0, updated together with Res.
- busy  output  1  high while a MUL/DIV iteration is in progress.
- done  output  1  one-cycle pulse marking completion of every accepted request.
- err  output  1  registered; set by an illegal opcode or divide-by-zero, cleared by the next completed legal operation.

Behaviour:
- Opcodes:
  - 0000 ADD: OP1+OP2 mod 2^WIDTH.
  - 0001 SUB: OP1-OP2 mod 2^WIDTH.
  - 0010 MUL: low WIDTH bits of the product.
  - 0011 DIV: unsigned quotient.
  - 0100 OR.
  - 0101 AND.
  - 0110 SLT: unsigned OP1<OP2, zero-extended.
  - 0111 NOP.
  - 1000-1111 illegal.
- Reset (async, any time, including mid-MUL/DIV):
  - Res=0, Z=1, busy=0, done=0, err=0.
  - FSM to IDLE, counter and internal regs cleared.
  - The in-flight operation is discarded with no done pulse.
  - Release is synchronous to the next edge.
- FSM states: IDLE, ITER, FIN.
- IDLE, start=1 sampled at edge k:
  - Single-cycle ops (ADD/SUB/AND/OR/SLT): Res, Z, err=0 and done=1 are all visible after edge k. Stay in IDLE. Latency 1.
  - NOP: done=1 after edge k; Res and Z unchanged; err=0.
  - Illegal opcode: done=1, err=1 after edge k; Res and Z unchanged.
  - DIV with OP2==0: done=1, err=1, Res={WIDTH{1}}, Z=0 after edge k. No iteration.
  - MUL, or DIV with OP2!=0: operands latched, counter=0, busy=1 after edge k, go to ITER.
- ITER:
  - One bit step per edge; counter increments.
  - After WIDTH steps (edge k+WIDTH), Res and Z are written, err=0, done=1, busy=0, and the FSM goes to FIN.
- FIN:
  - Returns to IDLE on the next edge and clears done.
  - start is not accepted in FIN.
  - Earliest next acceptance is edge k+WIDTH+2.
  - done is therefore always a single-cycle pulse.
- Request handling:
  - start while busy=1 or in FIN is ignored. It is not queued, and the operand/opcode inputs are don't-care.
  - Operands and opcode changing after acceptance must not affect the result.
  - Between completions, Res, Z and err hold their last values.
  - done is low in every cycle not listed above.
- Datapath widths:
  - MUL: 2*WIDTH internal accumulator, truncated on write.
  - DIV: WIDTH-bit remainder register plus 1 guard bit; the remainder is discarded.
- No X or Z values are ever driven on any output.

Test Plan:
1. Reset asserted mid-test, then released → Res=0, Z=1, busy=0, done=0, err=0. A start on the first edge after release is accepted normally.
2. ADD, OP1=0xFFFFFFFF, OP2=1 → Res=0, Z=1, done pulse 1 cycle after start; then SUB 5-3 back-to-back → Res=2, Z=0, done again the next cycle.
3. MUL, 7×6 (WIDTH=32) → busy for 32 cycles, Res=42 with done at edge k+32. Then 0x10000×0x10000 → Res=0, Z=1 (truncation).
4. DIV, 100/7 → Res=14 at edge k+32. DIV 5/0 → Res=0xFFFFFFFF, err=1, done after 1 cycle, busy never asserted. A following AND clears err.
5. Start MUL 3×3, change OP1/ALUSel and pulse start every cycle while busy → the only done corresponds to 9, and no extra op executes. Also assert rst at iteration 10 → no done; all outputs return to reset values.
6. ALUSel=1010 with Res=9 held → err=1, done pulse, Res=9 unchanged. Then NOP → err=0, Res=9. Repeat with WIDTH=8 to check DIV 255/16=15 at 8-cycle latency.

Source files
------------

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU. Single-cycle ADD/SUB/OR/AND/SLT/NOP; MUL (shift-add) and
// DIV (restoring) iterate over WIDTH clocks behind a start/busy/done handshake.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] OP1,
    input  logic [WIDTH-1:0] OP2,
    input  logic [3:0]       ALUSel,
    output logic [WIDTH-1:0] Res,
    output logic             Z,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_SLT = 4'b0110;
    localparam logic [3:0] OP_NOP = 4'b0111;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic               is_mul;
    logic [2*WIDTH-1:0] mcand, acc, acc_next;
    logic [WIDTH-1:0]   mplier, quo, quo_next, dvsr, rem, rem_next;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   fast_val, iter_val;
    logic               fast_op, div_zero, launch;

    // Decode of the request presented in IDLE.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        fast_op  = 1'b1;
        fast_val = '0;
        case (ALUSel)
            OP_ADD:  fast_val = OP1 + OP2;
            OP_SUB:  fast_val = OP1 - OP2;
            OP_OR:   fast_val = OP1 | OP2;
            OP_AND:  fast_val = OP1 & OP2;
            OP_SLT:  fast_val = {{(WIDTH-1){1'b0}}, OP1 < OP2};
            default: fast_op  = 1'b0;
        endcase
        div_zero = (ALUSel == OP_DIV) && (OP2 == '0);
        launch   = (ALUSel == OP_MUL) || ((ALUSel == OP_DIV) && !div_zero);
    end

    // One iteration step; the remainder never exceeds the divisor, so the
    // guard bit of the shifted remainder only exists inside the subtraction.
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
        rem_sh   = {rem, quo[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, dvsr};
        div_ge   = ~rem_diff[WIDTH];
        rem_next = div_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], div_ge};
        iter_val = is_mul ? acc_next[WIDTH-1:0] : quo_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && launch) state_next = ITER;
            ITER:    if (cnt == LAST) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: the iteration registers are reset too, so an aborted MUL/DIV leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Res    <= '0;
            Z      <= 1'b1;
            done   <= 1'b0;
            err    <= 1'b0;
            cnt    <= '0;
            is_mul <= 1'b0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            quo    <= '0;
            dvsr   <= '0;
            rem    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (fast_op) begin
                        Res  <= fast_val;
                        Z    <= (fast_val == '0);
                        err  <= 1'b0;
                        done <= 1'b1;
                    end else if (ALUSel == OP_NOP) begin
                        err  <= 1'b0;
                        done <= 1'b1;
                    end else if (div_zero) begin
                        Res  <= '1;
                        Z    <= 1'b0;
                        err  <= 1'b1;
                        done <= 1'b1;
                    end else if (launch) begin
                        cnt    <= '0;
                        is_mul <= (ALUSel == OP_MUL);
                        mcand  <= {{WIDTH{1'b0}}, OP1};
                        acc    <= '0;
                        mplier <= OP2;
                        quo    <= OP1;
                        dvsr   <= OP2;
                        rem    <= '0;
                    end else begin
                        err  <= 1'b1;
                        done <= 1'b1;
                    end
                end
                ITER: begin
                    cnt    <= cnt + 1'b1;
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    quo    <= quo_next;
                    rem    <= rem_next;
                    if (cnt == LAST) begin
                        Res  <= iter_val;
                        Z    <= (iter_val == '0);
                        err  <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == ITER);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a 32-bit and an 8-bit instance, expected results queued at
// acceptance and compared (value, flags, latency, busy, hold) when done is observed.
module tb_alu_seq;

    typedef struct packed {
        logic [63:0] res;
        logic        z;
        logic        err;
        logic        iter;
        logic [31:0] due;
    } exp_t;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, DIV = 4'd3;
    localparam logic [3:0] ORR = 4'd4, ANDD = 4'd5, SLT = 4'd6, NOP = 4'd7;

    logic        clk, rst;
    logic        start32, start8;
    logic [31:0] op1_32, op2_32, res32;
    logic [7:0]  op1_8, op2_8, res8;
    logic [3:0]  sel32, sel8;
    logic        z32, busy32, done32, err32;
    logic        z8, busy8, done8, err8;

    alu_seq #(.WIDTH(32), .CW(6)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .OP1(op1_32), .OP2(op2_32), .ALUSel(sel32),
        .Res(res32), .Z(z32), .busy(busy32), .done(done32), .err(err32)
    );

    alu_seq #(.WIDTH(8), .CW(4)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .OP1(op1_8), .OP2(op2_8), .ALUSel(sel8),
        .Res(res8), .Z(z8), .busy(busy8), .done(done8), .err(err8)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic        mon_en = 1'b0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [63:0] m_res[2];
    logic        m_z[2];
    int          next_free[2];
    logic [63:0] h_res[2];
    logic        h_z[2];
    logic        h_err[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mask(input int w, input logic [63:0] v);
        if (w >= 64) return v;
        return v & ((64'd1 << w) - 64'd1);
    endfunction

    task automatic clear_models();
        q0.delete();
        q1.delete();
        for (int u = 0; u < 2; u++) begin
            m_res[u] = '0; m_z[u] = 1'b1; next_free[u] = 0;
            h_res[u] = '0; h_z[u] = 1'b1; h_err[u] = 1'b0;
        end
    endtask

    // Drive a request now (caller is at a negedge) and queue its expectation if accepted.
    task automatic issue_now(input int u, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        int w, k;
        logic [63:0] am, bm, r;
        logic wr;
        exp_t e;
        if (u == 0) begin start32 = 1'b1; op1_32 = a[31:0]; op2_32 = b[31:0]; sel32 = op; end
        else        begin start8  = 1'b1; op1_8  = a[7:0];  op2_8  = b[7:0];  sel8  = op; end
        w = (u == 0) ? 32 : 8;
        k = cyc + 1;
        if (k < next_free[u]) return;
        am = mask(w, a); bm = mask(w, b);
        e = '0; wr = 1'b1; r = '0;
        case (op)
            ADD:  r = am + bm;
            SUB:  r = am - bm;
            MUL:  begin r = am * bm; e.iter = 1'b1; end
            DIV:  if (bm == 0) begin r = '1; e.err = 1'b1; end
                  else begin r = am / bm; e.iter = 1'b1; end
            ORR:  r = am | bm;
            ANDD: r = am & bm;
            SLT:  r = (am < bm) ? 64'd1 : 64'd0;
            NOP:  wr = 1'b0;
            default: begin wr = 1'b0; e.err = 1'b1; end
        endcase
        if (wr) begin m_res[u] = mask(w, r); m_z[u] = (m_res[u] == 0); end
        e.res = m_res[u];
        e.z   = m_z[u];
        e.due = e.iter ? 32'(k + w) : 32'(k);
        next_free[u] = e.iter ? k + w + 2 : k + 1;
        if (u == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic poke(input int u, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        issue_now(u, op, a, b);
    endtask

    task automatic issue(input int u, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        if (u == 0) start32 = 1'b0; else start8 = 1'b0;
        while (cyc + 1 < next_free[u]) @(negedge clk);
        issue_now(u, op, a, b);
    endtask

    task automatic idle(input int u);
        @(negedge clk);
        if (u == 0) start32 = 1'b0; else start8 = 1'b0;
    endtask

    task automatic drain(input int u);
        int n;
        for (int i = 0; i < 200; i++) begin
            n = (u == 0) ? q0.size() : q1.size();
            if (n == 0) return;
            @(posedge clk);
            #2;
        end
        n = (u == 0) ? q0.size() : q1.size();
        check($sformatf("u%0d_drain_timeout", u), 64'(n), 64'd0);
    endtask

    task automatic reset_checks(input int u);
        if (u == 0) begin
            check("u0_rst_res", {32'd0, res32}, 64'd0);
            check("u0_rst_z", {63'd0, z32}, 64'd1);
            check("u0_rst_busy", {63'd0, busy32}, 64'd0);
            check("u0_rst_done", {63'd0, done32}, 64'd0);
            check("u0_rst_err", {63'd0, err32}, 64'd0);
        end else begin
            check("u1_rst_res", {56'd0, res8}, 64'd0);
            check("u1_rst_z", {63'd0, z8}, 64'd1);
            check("u1_rst_busy", {63'd0, busy8}, 64'd0);
            check("u1_rst_done", {63'd0, done8}, 64'd0);
        end
    endtask

    // Per-cycle comparison of one instance against the scoreboard and the held values.
    task automatic mon(input int u);
        logic [63:0] r;
        logic zz, bz, dn, er, eb;
        exp_t f;
        int n;
        if (u == 0) begin r = {32'd0, res32}; zz = z32; bz = busy32; dn = done32; er = err32; n = q0.size(); end
        else        begin r = {56'd0, res8};  zz = z8;  bz = busy8;  dn = done8;  er = err8;  n = q1.size(); end
        f = '0;
        eb = 1'b0;
        if (n > 0) begin
            f  = (u == 0) ? q0[0] : q1[0];
            eb = f.iter && (cyc < int'(f.due));
        end
        check($sformatf("u%0d_busy", u), {63'd0, bz}, {63'd0, eb});
        if (dn) begin
            if (n == 0) begin
                check($sformatf("u%0d_spurious_done", u), 64'd1, 64'd0);
            end else begin
                if (u == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                check($sformatf("u%0d_res", u), r, f.res);
                check($sformatf("u%0d_z", u), {63'd0, zz}, {63'd0, f.z});
                check($sformatf("u%0d_err", u), {63'd0, er}, {63'd0, f.err});
                check($sformatf("u%0d_done_cycle", u), 64'(cyc), 64'(f.due));
                h_res[u] = f.res; h_z[u] = f.z; h_err[u] = f.err;
            end
        end else begin
            if (n > 0 && cyc >= int'(f.due)) begin
                check($sformatf("u%0d_missing_done", u), 64'd0, 64'd1);
                if (u == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                h_res[u] = f.res; h_z[u] = f.z; h_err[u] = f.err;
            end
            check($sformatf("u%0d_hold_res", u), r, h_res[u]);
            check($sformatf("u%0d_hold_z", u), {63'd0, zz}, {63'd0, h_z[u]});
            check($sformatf("u%0d_hold_err", u), {63'd0, er}, {63'd0, h_err[u]});
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en && !rst) begin
            mon(0);
            mon(1);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        start32 = 1'b0; op1_32 = '0; op2_32 = '0; sel32 = '0;
        start8  = 1'b0; op1_8  = '0; op2_8  = '0; sel8  = '0;
        clear_models();
        repeat (2) @(posedge clk);
        #1;
        reset_checks(0);
        reset_checks(1);

        // Release, then start on the very first edge: ADD wraps to zero, SUB back-to-back.
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        issue_now(0, ADD, 64'hFFFF_FFFF, 64'd1);
        issue(0, SUB, 64'd5, 64'd3);
        idle(0);
        drain(0);

        issue(0, MUL, 64'd7, 64'd6);         idle(0); drain(0);
        issue(0, MUL, 64'h10000, 64'h10000); idle(0); drain(0);
        issue(0, DIV, 64'd100, 64'd7);       idle(0); drain(0);
        issue(0, DIV, 64'd5, 64'd0);         idle(0); drain(0);
        issue(0, ANDD, 64'hF0, 64'h3C);      idle(0); drain(0);

        // Requests while busy or in FIN must be ignored.
        issue(0, MUL, 64'd3, 64'd3);
        for (int i = 0; i < 33; i++)
            poke(0, 4'($urandom_range(0, 15)), {32'd0, $urandom}, {32'd0, $urandom});
        idle(0);
        drain(0);

        issue(0, 4'b1010, 64'd1, 64'd2); idle(0); drain(0);
        issue(0, NOP, 64'd4, 64'd4);     idle(0); drain(0);

        // Reset in the middle of an iteration: no done, outputs back to reset values.
        issue(0, MUL, 64'd5, 64'd5);
        idle(0);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        mon_en = 1'b0;
        start32 = 1'b0;
        clear_models();
        #1;
        reset_checks(0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("u0_done_in_reset", {63'd0, done32}, 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        issue_now(0, ORR, 64'h30, 64'h0C);
        idle(0);
        drain(0);

        for (int i = 0; i < 16; i++) begin
            logic [63:0] b;
            b = ($urandom_range(0, 3) == 0) ? 64'd0 : {32'd0, $urandom};
            issue(0, 4'($urandom_range(0, 15)), {32'd0, $urandom}, b);
            idle(0);
            drain(0);
        end

        // 8-bit instance: shorter iteration latency and narrower wrap.
        issue(1, DIV, 64'd255, 64'd16); idle(1); drain(1);
        issue(1, MUL, 64'd15, 64'd17);  idle(1); drain(1);
        issue(1, MUL, 64'd16, 64'd16);  idle(1); drain(1);
        issue(1, DIV, 64'd7, 64'd0);    idle(1); drain(1);
        issue(1, SUB, 64'd3, 64'd5);    idle(1); drain(1);
        issue(1, SLT, 64'd3, 64'd5);    idle(1); drain(1);
        issue(1, 4'hF, 64'd1, 64'd1);   idle(1); drain(1);
        issue(1, NOP, 64'd0, 64'd0);    idle(1); drain(1);

        repeat (3) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
